fitness_session_ctrl: RTL and testbench
=======================================

Name: fitness_session_ctrl

Overview:
- Session controller and resource scheduler for the fitness datapath.
- Arbitrates the Run/Walk/Cycle buttons into one exclusive active activity.
- Generates the seconds tick and owns the per-activity seconds counters.
- On stop, time-shares one external 16x8 multiplier to compute all three calorie totals, then streams them out over a valid/ready interface.

Parameters:
- TICK_DIV, 50: clk cycles per seconds tick; minimum 2.
- MAX_SEC, 59: last seconds value before a counter wraps to 0.
- AUTO_PAUSE_CYC, 200: idle cycles before auto-pause; used only with FIT_AUTO_PAUSE_EN.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- btn_run, btn_walk, btn_cycle  in  1 each  level activity requests
- pause  in  1  single-cycle pulse; toggles ACTIVE/PAUSED
- stop  in  1  single-cycle pulse; ends session
- weight  in  8  user weight, sampled during CALC
- act_onehot  out  3  {cycle,walk,run} currently timed activity
- tick  out  1  one-cycle seconds pulse
- sec_run, sec_walk, sec_cycle  out  8 each  seconds counters
- mult_a  out  16  shared multiplier operand A
- mult_b  out  8  shared multiplier operand B
- mult_p  in  24  combinational product of mult_a * mult_b, same cycle
- cal_valid  out  1  calorie result valid
- cal_ready  in  1  consumer accepts result
- cal_sel  out  2  0=run, 1=walk, 2=cycle
- cal_out  out  24  calorie value for cal_sel
- busy  out  1  high in CALC or REPORT
- state  out  3  IDLE=0, ACTIVE=1, PAUSED=2, CALC=3, REPORT=4

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0; internal prescaler, temporary register and calorie registers 0.
- IDLE:
  - Any button high -> ACTIVE next cycle.
  - On that entry: seconds counters and prescaler cleared.
  - pause and stop ignored.
- ACTIVE arbitration:
  - Current activity is held while its button stays high.
  - When it is released, or nothing is selected, pick among high buttons with priority run > walk > cycle.
  - act_onehot is registered and updates one cycle after the button change.
  - No button high: act_onehot=0.
- ACTIVE timing:
  - Prescaler counts 0..TICK_DIV-1 only while act_onehot != 0.
  - tick=1 in the cycle the prescaler equals TICK_DIV-1.
  - Selected counter increments on that tick (visible next cycle); at MAX_SEC it wraps to 0.
  - Prescaler holds its value when act_onehot=0.
- PAUSED:
  - Entered from ACTIVE on a pause pulse.
  - act_onehot=0; prescaler and counters hold.
  - pause -> ACTIVE; arbitration restarts from no current activity.
- stop:
  - In ACTIVE or PAUSED -> CALC.
  - If pause and stop arrive in the same cycle, stop wins.
  - In ACTIVE, a tick coincident with stop is still counted.
- CALC: 6 cycles, step s=0..5, activity i=s/2 with constant K = 5, 8, 10.
  - Even step: mult_a={8'd0,weight}, mult_b=K; latch mult_p[15:0] into tmp.
  - Odd step: mult_a=tmp, mult_b=sec_i; latch mult_p into cal_reg[i].
  - Buttons, pause and stop ignored. mult_a and mult_b are 0 outside CALC.
  - After step 5 -> REPORT.
- REPORT:
  - cal_valid=1 with cal_sel=0 and cal_out=cal_reg[0].
  - A transfer completes in any cycle with cal_valid & cal_ready; cal_sel then advances the next cycle.
  - cal_out and cal_sel are stable while cal_valid=1 and cal_ready=0.
  - After the cal_sel=2 transfer: -> IDLE and cal_valid=0 next cycle.
  - Seconds counters keep their values until the next session starts.
- Reset mid-operation: asserting rst in any state immediately returns the block to reset values; no partial calorie result is emitted.

Optional Feature:
- Macro: FIT_AUTO_PAUSE_EN.
- Defined:
  - In ACTIVE, a counter of consecutive cycles with all buttons low runs.
  - Reaching AUTO_PAUSE_CYC -> PAUSED.
  - From an auto-pause, any button high or a pause pulse -> ACTIVE.
  - The counter clears on any button high or on a state change.
- Undefined: no idle counter; PAUSED is entered only via pause.

Test Plan:
- TICK_DIV=4; hold btn_run 20 cycles from IDLE -> state=1 and act_onehot=001; after 4 ticks sec_run=4; sec_walk=sec_cycle=0.
- btn_walk and btn_cycle raised together -> walk selected; then btn_run raised while walk held -> walk retained; drop walk -> run selected next cycle.
- sec_run=59 at tick -> sec_run=0; pause pulse -> state=2, no ticks for 30 cycles; pause pulse -> state=1 and counting resumes.
- weight=70, sec_run=10, sec_walk=5, sec_cycle=0, then stop -> busy for 6 CALC cycles; REPORT gives 3500, 2800, 0 with cal_ready always 1 -> IDLE 3 cycles after REPORT entry.
- Same results with cal_ready toggling 1 of 3 cycles -> cal_out and cal_sel stable while stalled; no result lost or duplicated.
- Reset pulse during CALC step 3 -> all outputs 0 immediately; with FIT_AUTO_PAUSE_EN and AUTO_PAUSE_CYC=10, ACTIVE with no buttons -> state=2 after 10 cycles.

Source files
------------

// File: rtl/fitness_session_ctrl.sv
// Session FSM: button arbitration, seconds timing, 6-cycle shared-multiplier calorie calc, then valid/ready report that holds under stall.
// Define FIT_AUTO_PAUSE_EN to add the idle auto-pause counter (AUTO_PAUSE_CYC cycles with no button -> PAUSED).
module fitness_session_ctrl #(
  parameter int TICK_DIV       = 50,
  parameter int MAX_SEC        = 59,
  parameter int AUTO_PAUSE_CYC = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_run,
  input  logic        btn_walk,
  input  logic        btn_cycle,
  input  logic        pause,
  input  logic        stop,
  input  logic [7:0]  weight,
  output logic [2:0]  act_onehot,
  output logic        tick,
  output logic [7:0]  sec_run,
  output logic [7:0]  sec_walk,
  output logic [7:0]  sec_cycle,
  output logic [15:0] mult_a,
  output logic [7:0]  mult_b,
  input  logic [23:0] mult_p,
  output logic        cal_valid,
  input  logic        cal_ready,
  output logic [1:0]  cal_sel,
  output logic [23:0] cal_out,
  output logic        busy,
  output logic [2:0]  state
);
  localparam int PW = $clog2(TICK_DIV);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_ACTIVE = 3'd1, S_PAUSED = 3'd2, S_CALC = 3'd3, S_REPORT = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    act_q, act_d, cur, arb, btns;
  logic [PW-1:0] presc_q;
  logic [7:0]    sec_run_q, sec_walk_q, sec_cycle_q, sec_sel, k_val;
  logic [2:0]    step_q;
  logic [15:0]   tmp_q;
  logic [23:0]   cal0_q, cal1_q, cal2_q;
  logic [1:0]    sel_q;
  logic          any_btn, tick_w, xfer, auto_trip, wake;

  assign btns    = {btn_cycle, btn_walk, btn_run};
  assign any_btn = |btns;
  assign tick_w  = (state_q == S_ACTIVE) && (act_q != 3'd0) && (presc_q == PW'(TICK_DIV - 1));
  assign xfer    = cal_valid && cal_ready;

  function automatic logic [7:0] inc_sec(input logic [7:0] s);
    return (s == 8'(MAX_SEC)) ? 8'd0 : s + 8'd1;
  endfunction

`ifdef FIT_AUTO_PAUSE_EN
  localparam int IW = $clog2(AUTO_PAUSE_CYC + 1);
  logic [IW-1:0] idle_q;
  logic          auto_q;

  assign auto_trip = (state_q == S_ACTIVE) && !any_btn && (idle_q == IW'(AUTO_PAUSE_CYC - 1));
  assign wake      = auto_q && any_btn;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_q <= '0;
      auto_q <= 1'b0;
    end else begin
      if (state_q != S_ACTIVE || state_d != state_q || any_btn) idle_q <= '0;
      else                                                      idle_q <= idle_q + IW'(1);
      // Only an idle-triggered pause may be woken by a button press
      if (state_d != S_PAUSED)           auto_q <= 1'b0;
      else if (state_q == S_ACTIVE)      auto_q <= auto_trip && !pause;
    end
  end
`else
  assign auto_trip = 1'b0;
  assign wake      = 1'b0;
`endif

  // Current activity is kept while its button holds; otherwise run > walk > cycle
  always_comb begin
    cur = (state_q == S_ACTIVE) ? act_q : 3'd0;
    arb = 3'd0;
    if ((cur & btns) != 3'd0) arb = cur;
    else if (btn_run)         arb = 3'b001;
    else if (btn_walk)        arb = 3'b010;
    else if (btn_cycle)       arb = 3'b100;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (any_btn) state_d = S_ACTIVE;
      S_ACTIVE: if (stop) state_d = S_CALC;
                else if (pause || auto_trip) state_d = S_PAUSED;
      S_PAUSED: if (stop) state_d = S_CALC;
                else if (pause || wake) state_d = S_ACTIVE;
      S_CALC:   if (step_q == 3'd5) state_d = S_REPORT;
      S_REPORT: if (xfer && sel_q == 2'd2) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    act_d = (state_d == S_ACTIVE) ? arb : 3'd0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    case (step_q[2:1])
      2'd0:    begin k_val = 8'd5;  sec_sel = sec_run_q;   end
      2'd1:    begin k_val = 8'd8;  sec_sel = sec_walk_q;  end
      default: begin k_val = 8'd10; sec_sel = sec_cycle_q; end
    endcase
    mult_a = 16'd0;
    mult_b = 8'd0;
    if (state_q == S_CALC) begin
      if (!step_q[0]) begin mult_a = {8'd0, weight}; mult_b = k_val;   end
      else            begin mult_a = tmp_q;          mult_b = sec_sel; end
    end
    case (sel_q)
      2'd0:    cal_out = cal0_q;
      2'd1:    cal_out = cal1_q;
      default: cal_out = cal2_q;
    endcase
    if (!cal_valid) cal_out = 24'd0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_q       <= 3'd0;
      presc_q     <= '0;
      sec_run_q   <= 8'd0;
      sec_walk_q  <= 8'd0;
      sec_cycle_q <= 8'd0;
      step_q      <= 3'd0;
      tmp_q       <= 16'd0;
      cal0_q      <= 24'd0;
      cal1_q      <= 24'd0;
      cal2_q      <= 24'd0;
      sel_q       <= 2'd0;
    end else begin
      act_q <= act_d;
      if (state_q == S_IDLE && state_d == S_ACTIVE) begin
        presc_q     <= '0;
        sec_run_q   <= 8'd0;
        sec_walk_q  <= 8'd0;
        sec_cycle_q <= 8'd0;
      end else if (tick_w) begin
        presc_q <= '0;
        if (act_q[0]) sec_run_q   <= inc_sec(sec_run_q);
        if (act_q[1]) sec_walk_q  <= inc_sec(sec_walk_q);
        if (act_q[2]) sec_cycle_q <= inc_sec(sec_cycle_q);
      end else if (state_q == S_ACTIVE && act_q != 3'd0) begin
        presc_q <= presc_q + PW'(1);
      end

      if (state_q == S_CALC) begin
        step_q <= step_q + 3'd1;
        if (!step_q[0]) tmp_q <= mult_p[15:0];
        else begin
          case (step_q[2:1])
            2'd0:    cal0_q <= mult_p;
            2'd1:    cal1_q <= mult_p;
            default: cal2_q <= mult_p;
          endcase
        end
      end else begin
        step_q <= 3'd0;
      end

      if (xfer) sel_q <= (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
    end
  end

  assign act_onehot = act_q;
  assign tick       = tick_w;
  assign sec_run    = sec_run_q;
  assign sec_walk   = sec_walk_q;
  assign sec_cycle  = sec_cycle_q;
  assign cal_valid  = (state_q == S_REPORT);
  assign cal_sel    = sel_q;
  assign busy       = (state_q == S_CALC) || (state_q == S_REPORT);
  assign state      = state_q;
endmodule

// File: tb/tb_fitness_session_ctrl.sv
// Directed bench for fitness_session_ctrl with TICK_DIV=4 and AUTO_PAUSE_CYC=10.
module tb_fitness_session_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        btn_run, btn_walk, btn_cycle, pause, stop, cal_ready;
  logic [7:0]  weight;
  logic [2:0]  act_onehot, state;
  logic        tick, cal_valid, busy;
  logic [7:0]  sec_run, sec_walk, sec_cycle, mult_b;
  logic [15:0] mult_a;
  logic [23:0] mult_p, cal_out;
  logic [1:0]  cal_sel;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;
  assign mult_p = 24'(mult_a) * 24'(mult_b);

  fitness_session_ctrl #(.TICK_DIV(4), .MAX_SEC(59), .AUTO_PAUSE_CYC(10)) dut (
    .clk(clk), .rst(rst), .btn_run(btn_run), .btn_walk(btn_walk), .btn_cycle(btn_cycle),
    .pause(pause), .stop(stop), .weight(weight), .act_onehot(act_onehot), .tick(tick),
    .sec_run(sec_run), .sec_walk(sec_walk), .sec_cycle(sec_cycle), .mult_a(mult_a),
    .mult_b(mult_b), .mult_p(mult_p), .cal_valid(cal_valid), .cal_ready(cal_ready),
    .cal_sel(cal_sel), .cal_out(cal_out), .busy(busy), .state(state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  // Run 10 ticks then walk 5 ticks; stop lands on the final walk tick
  task automatic run_session(input logic with_pause);
    btn_run = 1'b1;
    step();
    chk("sess_enter", {29'd0, state}, 32'd1);
    for (int k = 0; k < 60; k++) begin
      if (k == 39) begin btn_run = 1'b0; btn_walk = 1'b1; end
      if (k == 59) begin
        btn_walk = 1'b0;
        stop = 1'b1;
        pause = with_pause;
      end
      step();
      stop = 1'b0;
      pause = 1'b0;
    end
    chk("sess_calc", {29'd0, state}, 32'd3);
    chk("sess_run", {24'd0, sec_run}, 32'd10);
    chk("sess_walk", {24'd0, sec_walk}, 32'd5);
    chk("sess_cycle", {24'd0, sec_cycle}, 32'd0);
  endtask

  initial begin
    logic [23:0] exp_cal [3];
    logic [23:0] got_cal [3];
    logic [1:0]  got_sel [3];
    logic [1:0]  psel;
    logic [23:0] pout;
    logic        stalled, found;
    logic [7:0]  held;
    int          nt, n;

    exp_cal[0] = 24'd3500; exp_cal[1] = 24'd2800; exp_cal[2] = 24'd0;
    rst = 1'b0; btn_run = 0; btn_walk = 0; btn_cycle = 0; pause = 0; stop = 0;
    cal_ready = 1'b1; weight = 8'd70;
    #2;
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_act", {29'd0, act_onehot}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, cal_valid}, 32'd0);
    chk("rst_mult_a", {16'd0, mult_a}, 32'd0);
    chk("rst_cal_out", {8'd0, cal_out}, 32'd0);
    step();
    rst = 1'b1;

    // Basic timing: run held, 4 ticks in 16 cycles
    pause = 1'b1; stop = 1'b1;
    step();
    chk("idle_ignores_ctl", {29'd0, state}, 32'd0);
    pause = 1'b0; stop = 1'b0;
    btn_run = 1'b1;
    step();
    chk("t1_state", {29'd0, state}, 32'd1);
    chk("t1_act", {29'd0, act_onehot}, 32'd1);
    nt = 0;
    for (int i = 0; i < 16; i++) begin
      nt += int'(tick);
      step();
    end
    chk("t1_ticks", nt, 32'd4);
    chk("t1_sec_run", {24'd0, sec_run}, 32'd4);
    chk("t1_sec_walk", {24'd0, sec_walk}, 32'd0);
    chk("t1_sec_cycle", {24'd0, sec_cycle}, 32'd0);

    // Arbitration
    btn_run = 1'b0; btn_walk = 1'b1; btn_cycle = 1'b1;
    step();
    chk("arb_walk", {29'd0, act_onehot}, 32'd2);
    btn_run = 1'b1;
    step();
    chk("arb_hold_walk", {29'd0, act_onehot}, 32'd2);
    btn_walk = 1'b0;
    step();
    chk("arb_run", {29'd0, act_onehot}, 32'd1);
    btn_run = 1'b0; btn_cycle = 1'b0;
    step();
    chk("arb_none", {29'd0, act_onehot}, 32'd0);
    do_reset();

    // Calorie calc with cal_ready held high
    run_session(1'b0);
    chk("calc0_a", {16'd0, mult_a}, 32'd70);
    chk("calc0_b", {24'd0, mult_b}, 32'd5);
    step();
    chk("calc1_a", {16'd0, mult_a}, 32'd350);
    chk("calc1_b", {24'd0, mult_b}, 32'd10);
    for (int i = 0; i < 4; i++) begin
      chk("calc_busy", {31'd0, busy}, 32'd1);
      step();
    end
    chk("calc_last", {29'd0, state}, 32'd3);
    step();
    for (int i = 0; i < 3; i++) begin
      chk("rep_valid", {31'd0, cal_valid}, 32'd1);
      chk("rep_sel", {30'd0, cal_sel}, i);
      chk("rep_out", {8'd0, cal_out}, {8'd0, exp_cal[i]});
      step();
    end
    chk("rep_idle", {29'd0, state}, 32'd0);
    chk("rep_valid_low", {31'd0, cal_valid}, 32'd0);
    chk("rep_secs_kept", {24'd0, sec_run}, 32'd10);

    // Wrap at MAX_SEC, then pause / resume
    btn_run = 1'b1;
    step();
    chk("entry_clear", {24'd0, sec_walk}, 32'd0);
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (sec_run == 8'd59 && tick) begin found = 1'b1; break; end
      step();
    end
    chk("wrap_found", {31'd0, found}, 32'd1);
    step();
    chk("wrap_zero", {24'd0, sec_run}, 32'd0);
    pause = 1'b1;
    step();
    pause = 1'b0;
    chk("pause_state", {29'd0, state}, 32'd2);
    chk("pause_act", {29'd0, act_onehot}, 32'd0);
    held = sec_run;
    nt = 0;
    for (int i = 0; i < 30; i++) begin
      nt += int'(tick);
      step();
    end
    chk("pause_ticks", nt, 32'd0);
    chk("pause_hold", {24'd0, sec_run}, {24'd0, held});
    pause = 1'b1;
    step();
    pause = 1'b0;
    chk("resume_state", {29'd0, state}, 32'd1);
    for (int i = 0; i < 8; i++) step();
    chk("resume_count", {31'd0, (sec_run != held)}, 32'd1);

    // Reset during CALC step 3
    stop = 1'b1;
    step();
    stop = 1'b0;
    step(); step(); step();
    chk("pre_rst_calc", {29'd0, state}, 32'd3);
    rst = 1'b0;
    #1;
    chk("mid_rst_state", {29'd0, state}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_a", {16'd0, mult_a}, 32'd0);
    chk("mid_rst_b", {24'd0, mult_b}, 32'd0);
    chk("mid_rst_sec", {24'd0, sec_run}, 32'd0);
    chk("mid_rst_valid", {31'd0, cal_valid}, 32'd0);
    btn_run = 1'b0;
    step();
    rst = 1'b1;

    // Stalled report, with pause+stop coincident at session end
    run_session(1'b1);
    n = 0;
    stalled = 1'b0;
    psel = 2'd0;
    pout = 24'd0;
    for (int c = 0; c < 40 && n < 3; c++) begin
      cal_ready = (c % 3 == 2);
      #1;
      if (cal_valid) begin
        if (stalled) begin
          chk("stall_sel", {30'd0, cal_sel}, {30'd0, psel});
          chk("stall_out", {8'd0, cal_out}, {8'd0, pout});
        end
        if (cal_ready) begin
          got_cal[n] = cal_out;
          got_sel[n] = cal_sel;
          n++;
        end
        stalled = !cal_ready;
        psel = cal_sel;
        pout = cal_out;
      end
      step();
    end
    cal_ready = 1'b1;
    chk("stall_count", n, 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < n) begin
        chk("stall_got_sel", {30'd0, got_sel[i]}, i);
        chk("stall_got_out", {8'd0, got_cal[i]}, {8'd0, exp_cal[i]});
      end
    end
    chk("stall_idle", {29'd0, state}, 32'd0);

`ifdef FIT_AUTO_PAUSE_EN
    btn_run = 1'b1;
    step();
    btn_run = 1'b0;
    for (int i = 0; i < 9; i++) step();
    chk("auto_before", {29'd0, state}, 32'd1);
    step();
    chk("auto_paused", {29'd0, state}, 32'd2);
    btn_walk = 1'b1;
    step();
    chk("auto_wake", {29'd0, state}, 32'd1);
    btn_walk = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
